// File: rtl/bsg_dff_pipe.sv
// Elastic register pipeline: els_p stages of valid/data with bubble collapsing,
// a valid/ready producer side and a valid/yumi consumer side.

module bsg_dff_pipe_chk #(
    parameter int els_p   = 2,
    parameter int cnt_w_p = 2
) (
    input logic               clk_i,
    input logic               reset_i,
    input logic               yumi_i,
    input logic               v_o,
    input logic [cnt_w_p-1:0] count_o
);

    yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
        else $error("bsg_dff_pipe: yumi_i asserted while v_o is low");

    count_in_range: assert property (@(posedge clk_i) disable iff (reset_i) count_o <= cnt_w_p'(els_p))
        else $error("bsg_dff_pipe: count_o exceeds els_p");

endmodule

module bsg_dff_pipe #(
    parameter int width_p = 64,
    parameter int els_p   = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int cnt_w_lp = $clog2(els_p + 1);

    function automatic logic [cnt_w_lp-1:0] popcount(input logic [els_p-1:0] bits);
        logic [cnt_w_lp-1:0] sum;
        sum = '0;
        for (int i = 0; i < els_p; i++) begin
            sum = sum + cnt_w_lp'(bits[i]);
        end
        return sum;
    endfunction

    logic [els_p-1:0]   valid_r;
    logic [width_p-1:0] data_r [els_p];
    logic [cnt_w_lp-1:0] count_r;

    logic [els_p-1:0]   en_s;
    logic [els_p-1:0]   valid_n_s;
    logic [width_p-1:0] data_n_s [els_p];

    // Stage k may load when the consumer takes the output or any stage from k to the end is empty.
    always_comb begin
        logic acc_s;
        en_s  = '0;
        acc_s = 1'b0;
        for (int k = 0; k < els_p; k++) begin
            acc_s = yumi_i;
            for (int j = k; j < els_p; j++) begin
                acc_s = acc_s | ~valid_r[j];
            end
            en_s[k] = acc_s;
        end
    end

    // Next-state of every stage: enabled stages take their upstream neighbour, others hold.
    always_comb begin
        valid_n_s = valid_r;
        data_n_s  = data_r;
        if (en_s[0]) begin
            valid_n_s[0] = v_i;
            data_n_s[0]  = data_i;
        end else begin
            valid_n_s[0] = valid_r[0];
            data_n_s[0]  = data_r[0];
        end
        for (int k = 1; k < els_p; k++) begin
            if (en_s[k]) begin
                valid_n_s[k] = valid_r[k-1];
                data_n_s[k]  = data_r[k-1];
            end else begin
                valid_n_s[k] = valid_r[k];
                data_n_s[k]  = data_r[k];
            end
        end
    end

    // Stage registers and occupancy count; reset discards everything at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_r <= '0;
            count_r <= '0;
            for (int k = 0; k < els_p; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            valid_r <= valid_n_s;
            data_r  <= data_n_s;
            count_r <= popcount(valid_n_s);
        end
    end

    assign ready_o = en_s[0];
    assign v_o     = valid_r[els_p-1];
    assign data_o  = data_r[els_p-1];
    assign count_o = count_r;

    bsg_dff_pipe_chk #(
        .els_p   (els_p),
        .cnt_w_p (cnt_w_lp)
    ) u_chk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .yumi_i  (yumi_i),
        .v_o     (v_o),
        .count_o (count_r)
    );

endmodule

// File: tb/tb_bsg_dff_pipe.sv
// Directed literal checks on a 3-stage pipe plus queue-of-positions models
// compared every cycle against 1-, 2- and 5-stage pipes under random traffic.

module tb_bsg_dff_pipe;

    localparam int RAND_CYC = 10000;

    logic       clk_s = 1'b0;
    logic       rst_s = 1'b1;
    logic       v_s = 1'b0;
    logic [7:0] d_s = 8'h00;
    logic       y_s = 1'b0;
    logic       rdy_s;
    logic       vo_s;
    logic [7:0] do_s;
    logic [1:0] cnt_s;
    logic       rand_go_s = 1'b0;

    int total_r = 0;
    int bad_r   = 0;

    always #5 clk_s = ~clk_s;

    bsg_dff_pipe #(.width_p(8), .els_p(3)) u_dut (
        .clk_i   (clk_s),
        .reset_i (rst_s),
        .v_i     (v_s),
        .data_i  (d_s),
        .ready_o (rdy_s),
        .v_o     (vo_s),
        .data_o  (do_s),
        .yumi_i  (y_s),
        .count_o (cnt_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_r = total_r + 1;
        if (act !== exp) begin
            bad_r = bad_r + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int E = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
        logic                     gv_s = 1'b0;
        logic [7:0]               gd_s = 8'h00;
        logic                     gy_s = 1'b0;
        logic                     grdy_s;
        logic                     gvo_s;
        logic [7:0]               gdo_s;
        logic [$clog2(E+1)-1:0]   gcnt_s;

        bsg_dff_pipe #(.width_p(8), .els_p(E)) u_rdut (
            .clk_i   (clk_s),
            .reset_i (rst_s),
            .v_i     (gv_s),
            .data_i  (gd_s),
            .ready_o (grdy_s),
            .v_o     (gvo_s),
            .data_o  (gdo_s),
            .yumi_i  (gy_s),
            .count_o (gcnt_s)
        );

        // Model: items in acceptance order (head first), each with its stage position.
        initial begin
            int         mp[$];
            logic [7:0] md[$];
            int         np[$];
            logic [7:0] nd[$];
            bit         mv[E];
            int         n;
            bit         vo_m;
            bit         rdy_m;
            wait (rand_go_s);
            for (int c = 0; c < RAND_CYC; c++) begin
                @(negedge clk_s);
                n    = mp.size();
                vo_m = (n > 0) && (mp[0] == E - 1);
                chk($sformatf("e%0d_v_o", E), 32'(gvo_s), 32'(vo_m));
                if (vo_m) chk($sformatf("e%0d_data_o", E), 32'(gdo_s), 32'(md[0]));
                chk($sformatf("e%0d_count_o", E), 32'(gcnt_s), 32'(n));
                gv_s = 1'($urandom_range(0, 1));
                gd_s = 8'($urandom);
                gy_s = 1'($urandom_range(0, 1)) & vo_m;
                for (int i = 0; i < n; i++) begin
                    if (i == 0) mv[i] = (mp[0] == E - 1) ? gy_s : 1'b1;
                    else        mv[i] = (mp[i] + 1 < mp[i-1]) || mv[i-1];
                end
                rdy_m = (n == 0) || (mp[n-1] != 0) || mv[n-1];
                #1;
                chk($sformatf("e%0d_ready_o", E), 32'(grdy_s), 32'(rdy_m));
                @(posedge clk_s);
                np.delete();
                nd.delete();
                for (int i = 0; i < n; i++) begin
                    if (!mv[i]) begin
                        np.push_back(mp[i]);
                        nd.push_back(md[i]);
                    end else if (mp[i] != E - 1) begin
                        np.push_back(mp[i] + 1);
                        nd.push_back(md[i]);
                    end
                end
                if (gv_s && rdy_m) begin
                    np.push_back(0);
                    nd.push_back(gd_s);
                end
                mp = np;
                md = nd;
            end
            gv_s = 1'b0;
            gy_s = 1'b0;
        end
    end

    initial begin
        #3;
        chk("rst_v_o", 32'(vo_s), 32'h0);
        chk("rst_data_o", 32'(do_s), 32'h0);
        chk("rst_count_o", 32'(cnt_s), 32'h0);
        repeat (2) @(negedge clk_s);
        rst_s = 1'b0;
        #1 chk("ready_after_rst", 32'(rdy_s), 32'h1);

        // single item latency with a consumer that always takes
        v_s = 1'b1; d_s = 8'h11;
        @(negedge clk_s); v_s = 1'b0;
        chk("lat_c1_v_o", 32'(vo_s), 32'h0);
        @(negedge clk_s);
        chk("lat_c2_v_o", 32'(vo_s), 32'h0);
        @(negedge clk_s);
        chk("lat_c3_v_o", 32'(vo_s), 32'h1);
        chk("lat_c3_data_o", 32'(do_s), 32'h11);
        chk("lat_c3_count_o", 32'(cnt_s), 32'h1);
        y_s = 1'b1;
        @(negedge clk_s); y_s = 1'b0;
        chk("lat_c4_v_o", 32'(vo_s), 32'h0);
        chk("lat_c4_count_o", 32'(cnt_s), 32'h0);

        // fill with a stalled consumer
        v_s = 1'b1; d_s = 8'hA1;
        #1 chk("fill_a1_ready", 32'(rdy_s), 32'h1);
        @(negedge clk_s); d_s = 8'hA2;
        #1 chk("fill_a2_ready", 32'(rdy_s), 32'h1);
        @(negedge clk_s); d_s = 8'hA3;
        #1 chk("fill_a3_ready", 32'(rdy_s), 32'h1);
        @(negedge clk_s); d_s = 8'hA4;
        #1 chk("full_ready", 32'(rdy_s), 32'h0);
        chk("full_count_o", 32'(cnt_s), 32'h3);
        chk("full_v_o", 32'(vo_s), 32'h1);
        chk("full_data_o", 32'(do_s), 32'hA1);
        @(negedge clk_s);
        chk("stall_ready", 32'(rdy_s), 32'h0);
        chk("stall_count_o", 32'(cnt_s), 32'h3);
        chk("stall_data_o", 32'(do_s), 32'hA1);

        // full pipe accepts and emits in the same cycle
        y_s = 1'b1;
        #1 chk("pass_ready", 32'(rdy_s), 32'h1);
        @(negedge clk_s);
        chk("drain_a2", 32'(do_s), 32'hA2);
        chk("drain_a2_count", 32'(cnt_s), 32'h3);
        v_s = 1'b0;
        @(negedge clk_s);
        chk("drain_a3", 32'(do_s), 32'hA3);
        chk("drain_a3_count", 32'(cnt_s), 32'h2);
        @(negedge clk_s);
        chk("drain_a4", 32'(do_s), 32'hA4);
        chk("drain_a4_count", 32'(cnt_s), 32'h1);
        @(negedge clk_s);
        chk("drain_empty_v_o", 32'(vo_s), 32'h0);
        chk("drain_empty_count", 32'(cnt_s), 32'h0);
        y_s = 1'b0;

        // reset between edges discards in-flight items
        v_s = 1'b1; d_s = 8'h33;
        @(negedge clk_s); d_s = 8'h44;
        @(negedge clk_s); v_s = 1'b0;
        @(negedge clk_s);
        chk("pre_rst_v_o", 32'(vo_s), 32'h1);
        chk("pre_rst_data_o", 32'(do_s), 32'h33);
        chk("pre_rst_count_o", 32'(cnt_s), 32'h2);
        #2 rst_s = 1'b1;
        #1;
        chk("async_rst_v_o", 32'(vo_s), 32'h0);
        chk("async_rst_data_o", 32'(do_s), 32'h0);
        chk("async_rst_count_o", 32'(cnt_s), 32'h0);
        @(negedge clk_s); rst_s = 1'b0;
        #1 chk("post_rst_ready", 32'(rdy_s), 32'h1);
        v_s = 1'b1; d_s = 8'h55;
        @(negedge clk_s); d_s = 8'h66;
        @(negedge clk_s); v_s = 1'b0;
        @(negedge clk_s);
        chk("post_rst_first", 32'(do_s), 32'h55);
        chk("post_rst_first_v", 32'(vo_s), 32'h1);
        chk("post_rst_count2", 32'(cnt_s), 32'h2);
        y_s = 1'b1;
        @(negedge clk_s);
        chk("post_rst_second", 32'(do_s), 32'h66);
        chk("post_rst_second_v", 32'(vo_s), 32'h1);
        @(negedge clk_s);
        chk("post_rst_empty", 32'(vo_s), 32'h0);
        chk("post_rst_count0", 32'(cnt_s), 32'h0);
        y_s = 1'b0;

        rand_go_s = 1'b1;
        repeat (RAND_CYC + 4) @(negedge clk_s);
        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule

// File: doc/bsg_dff_pipe.md
BSG_DFF_PIPE -- requirements
Module: bsg_dff_pipe

Interface
REQ-001 The module SHALL have parameter width_p, default 64, meaning the data width in bits (>=1).
REQ-002 The module SHALL have parameter els_p, default 2, meaning the number of register stages (>=1).
REQ-003 The module SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset_i, input, 1, meaning the asynchronous, active-high reset.
REQ-005 The module SHALL have port v_i, input, 1, meaning the producer offers data_i this cycle.
REQ-006 The module SHALL have port data_i, input, width_p, meaning the producer data.
REQ-007 The module SHALL have port ready_o, output, 1, meaning stage 0 accepts data this cycle.
REQ-008 The module SHALL have port v_o, output, 1, meaning the output stage holds valid data.
REQ-009 The module SHALL have port data_o, output, width_p, meaning the output-stage data.
REQ-010 The module SHALL have port yumi_i, input, 1, meaning the consumer takes data_o this cycle.
REQ-011 The module SHALL have port count_o, output, $clog2(els_p+1), meaning the number of valid stages.

Function
REQ-012 Stages SHALL be numbered 0 (input side) to els_p-1 (output side), each holding a valid bit and a width_p data register.
REQ-013 Stage els_p-1 SHALL advance when yumi_i=1; stage k<els_p-1 SHALL advance when stage k+1 is enabled.
REQ-014 Stage k SHALL be enabled when its valid bit is 0 or it advances (bubble collapsing).
REQ-015 ready_o SHALL equal the stage 0 enable, computed combinationally from yumi_i and the valid bits, with no registered delay.
REQ-016 An enabled stage 0 SHALL load data_i and set valid to (v_i & ready_o).
REQ-017 An enabled stage k>0 SHALL load the data and valid bit of stage k-1.
REQ-018 A disabled stage SHALL hold its data and valid bit unchanged.
REQ-019 v_o and data_o SHALL be the valid bit and data of stage els_p-1, taken directly from registers.
REQ-020 Latency: an item accepted at edge t into an empty, unstalled pipe SHALL present on v_o/data_o after edge t+els_p-1, i.e. els_p cycles after the accepting cycle.
REQ-021 With v_i=1 and yumi_i=1 held, throughput SHALL be one item per cycle with no bubbles inserted.
REQ-022 Items SHALL leave in acceptance order; no item SHALL be dropped or duplicated.
REQ-023 yumi_i=1 while v_o=0 SHALL be a protocol error; the design SHALL treat it as a no-op on stage els_p-1 and SHALL flag it with a simulation-only assertion.
REQ-024 v_i=1 while ready_o=0 SHALL change no state; the producer holds its data.
REQ-025 Full (all valid) with yumi_i=1 and v_i=1 SHALL accept and emit in the same cycle; count_o SHALL be unchanged.
REQ-026 Full with yumi_i=0 SHALL drive ready_o=0.
REQ-027 count_o SHALL equal the population count of the valid bits, registered or derived from registers, and SHALL never exceed els_p.
REQ-028 With els_p=1, ready_o SHALL equal (~v_o | yumi_i).

Reset
REQ-029 While reset_i=1, all valid bits SHALL be 0, all data registers SHALL be 0, v_o=0, data_o=0 and count_o=0, independent of clk_i.
REQ-030 Assertion of reset_i mid-operation SHALL discard all in-flight items immediately.
REQ-031 In the first edge after reset_i deasserts, ready_o SHALL be 1 and v_i SHALL be accepted normally.

Verification
REQ-032 width_p=8, els_p=3, yumi_i=1; v_i=1 with data_i=0x11 for one cycle -> v_o=1, data_o=0x11 exactly 3 cycles later, for one cycle only.
REQ-033 width_p=8, els_p=3, yumi_i=0; offer 0xA1,0xA2,0xA3,0xA4 -> first three accepted, ready_o=0 on the fourth, count_o=3, data_o=0xA1.
REQ-034 Continue from REQ-033 with yumi_i=1 and 0xA4 held -> 0xA4 is accepted in the same cycle 0xA1 leaves; output order is 0xA1,0xA2,0xA3,0xA4; count_o stays 3.
REQ-035 Fill with 2 items, assert reset_i asynchronously between edges -> v_o, data_o and count_o read 0 before the next edge; after deassertion, items 0x55 then 0x66 emerge in order.
REQ-036 Random v_i/yumi_i streams at 50% density, els_p in {1,2,5}, 10k cycles -> scoreboard shows in-order, lossless delivery, count_o equals the model occupancy, and no protocol assertions fire.
